spi_accel_target: RTL and testbench
===================================

// Module: spi_accel_target
// PURPOSE
//   SPI target (slave) end of the accelerometer link: the mode-3, 4-wire responder to the sensor-read master.
//   Decodes a command byte {R/W, MB, A[5:0]}, serves register reads and accepts configuration writes.
//   Presents the DEVID, BW_RATE (0x2C), POWER_CTL (0x2D), DATA_FORMAT (0x31) and DATAX0..DATAZ1 (0x32-0x37) registers.
//   Used as an on-FPGA sensor stand-in for link bring-up and as the bench model for the master.
// PARAMETERS
//   SYNC_STAGES  2      flops in sclk/cs_n/sdi synchronisers (>=2)
//   DEVID        8'hE5  value read at address 0x00
//   BW_RATE_RST  8'h0A  reset value of BW_RATE (0x2C)
// PORTS
//   clk          in   1   system clock (50 MHz); must be >= 8x sclk frequency
//   rst_n        in   1   asynchronous active-low reset
//   sclk         in   1   SPI clock from master, idles high (CPOL=1, CPHA=1)
//   cs_n         in   1   SPI chip select, active low
//   sdi          in   1   master-to-target serial data
//   sdo          out  1   target-to-master serial data
//   sdo_oe       out  1   high while sdo is driven (read data phase only)
//   sample_valid in   1   new X/Y/Z sample offered
//   sample_ready out  1   sample accepted when valid && ready
//   sample_x     in   16  X sample, two's complement
//   sample_y     in   16  Y sample
//   sample_z     in   16  Z sample
//   bw_rate      out  8   BW_RATE register
//   power_ctl    out  8   POWER_CTL register
//   data_format  out  8   DATA_FORMAT register
//   cfg_wr       out  1   one-clk pulse per committed register write
//   busy         out  1   transaction in progress (synchronised cs_n low)
// BEHAVIOUR
// - Reset: sdo=0, sdo_oe=0, sample_ready=1, cfg_wr=0, busy=0, bw_rate=BW_RATE_RST, power_ctl=0, data_format=0.
//   Reset also clears the data registers and the pending sample, and puts the FSM in IDLE.
// - Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised values.
//   sdi is sampled on a rising sclk edge; sdo changes on a falling sclk edge, one clk after edge detect.
// - FSM IDLE -> CMD on synchronised cs_n fall. On that fall, DATAX0..DATAZ1 are copied into a snapshot.
//   All reads of 0x32-0x37 in the transaction return the snapshot, so multi-byte reads are coherent.
// - CMD: shift 8 bits MSB first. After the 8th rising edge, latch R=bit7, MB=bit6, addr=bit[5:0], then go to DATA.
// - DATA, read: load the byte at addr into the shift register. Drive the MSB on the next falling edge, then 8 bits MSB first.
//   sdo_oe=1 from that falling edge until cs_n rises.
//   Read map: 0x00=DEVID, 0x2C/0x2D/0x31 = the registers, 0x32-0x37 = {X[7:0],X[15:8],Y[7:0],Y[15:8],Z[7:0],Z[15:8]}.
//   Every other address reads 0x00.
// - DATA, write: after each 8th rising edge, commit the byte if addr is 0x2C/0x2D/0x31, and pulse cfg_wr for one clk.
//   Bytes to any other address are discarded with no cfg_wr pulse.
// - After each data byte: if MB=1, addr increments and wraps 0x3F->0x00.
//   If MB=0, addr holds: reads repeat the same byte, and writes after the first byte are ignored.
// - cs_n rise (any state) -> IDLE. A partial byte is discarded (never committed), and sdo_oe drops within 1 clk of the detected rise.
// - Sample handshake: when cs_n is high, an accepted sample updates the data registers on the next clk.
//   When busy, an accepted sample is held pending and sample_ready=0.
//   The pending sample is applied on the clk after cs_n rises; sample_ready then returns to 1.
// - A cs_n fall and a sample accept in the same clk: the snapshot takes the old data, and the new sample goes to pending.
// - sclk edges while cs_n is high are ignored.
// TESTING
// - Read DEVID: cs_n low, cmd 0x80, 8 clocks -> sdo returns 0xE5, sdo_oe=1 only during the data byte.
// - Config writes: cmd 0x31 data 0x00, then cmd 0x2C data 0x0F -> data_format=0x00, bw_rate=0x0F, exactly two cfg_wr pulses.
// - Multi-byte read:
//   - setup: sample X=0x1234, Y=0xFFFE, Z=0x0100
//   - stimulus: cmd 0xF2, 16 data clocks
//   - response: bytes 0x34, 0x12
//   - coherence: a new sample offered mid-transfer is held (sample_ready=0) and visible on the next read
// - Wrap and MB=0:
//   - MB=1 read from 0x3F for 2 bytes -> 0x00 then DEVID 0xE5
//   - cmd 0x2C (MB=0) write 0x0A, 0x55 -> bw_rate=0x0A, one cfg_wr pulse
// - Abort: cs_n rises after 5 bits of a write data byte to 0x2D -> power_ctl unchanged, no cfg_wr, next transaction decodes correctly.
// - Reset mid-read: rst_n low during the data phase -> sdo_oe=0, registers at reset values, busy=0; after release DEVID read passes.

Source files
------------

// File: rtl/spi_accel_target.sv
// rtl/spi_accel_target.sv - SPI mode-3 target emulating the accelerometer register map
module spi_accel_target #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEVID       = 8'hE5,
  parameter logic [7:0]  BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic [7:0]  bw_rate,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        cfg_wr,
  output logic        busy
);

  localparam logic [5:0] ADDR_DEVID = 6'h00;
  localparam logic [5:0] ADDR_BW    = 6'h2C;
  localparam logic [5:0] ADDR_PWR   = 6'h2D;
  localparam logic [5:0] ADDR_FMT   = 6'h31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
  logic sclk_s, cs_s, sdi_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  logic [6:0]  rx_sr;
  logic [7:0]  tx_sr;
  logic [7:0]  wr_byte;
  logic [7:0]  read_data;
  logic [2:0]  bit_cnt;
  logic        byte_done;
  logic        rw, mb, first_byte, tx_load;
  logic [5:0]  addr;

  logic [15:0] data_x, data_y, data_z;
  logic [15:0] snap_x, snap_y, snap_z;
  logic [15:0] pend_x, pend_y, pend_z;
  logic        pend_valid;

  // Idle-high reset values keep a spurious edge from appearing at reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      sdi_sync  <= '0;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_q    <= sclk_s;
      cs_q      <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = cs_s & ~cs_q;
  assign cs_fall   = ~cs_s & cs_q;

  assign busy         = ~cs_s;
  assign sample_ready = ~pend_valid;

  assign wr_byte   = {rx_sr, sdi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7) && (state_q != ST_IDLE) && !cs_rise;

  always_comb begin
    read_data = 8'h00;
    case (addr)
      ADDR_DEVID: read_data = DEVID;
      ADDR_BW:    read_data = bw_rate;
      ADDR_PWR:   read_data = power_ctl;
      ADDR_FMT:   read_data = data_format;
      6'h32:      read_data = snap_x[7:0];
      6'h33:      read_data = snap_x[15:8];
      6'h34:      read_data = snap_y[7:0];
      6'h35:      read_data = snap_y[15:8];
      6'h36:      read_data = snap_z[7:0];
      6'h37:      read_data = snap_z[15:8];
      default:    read_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (cs_rise)        state_d = ST_IDLE;
        else if (byte_done) state_d = ST_DATA;
      end
      ST_DATA: if (cs_rise) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr       <= '0;
      tx_sr       <= '0;
      bit_cnt     <= '0;
      rw          <= 1'b0;
      mb          <= 1'b0;
      first_byte  <= 1'b0;
      tx_load     <= 1'b0;
      addr        <= '0;
      sdo         <= 1'b0;
      sdo_oe      <= 1'b0;
      cfg_wr      <= 1'b0;
      bw_rate     <= BW_RATE_RST;
      power_ctl   <= '0;
      data_format <= '0;
      snap_x      <= '0;
      snap_y      <= '0;
      snap_z      <= '0;
    end else begin
      cfg_wr  <= 1'b0;
      tx_load <= 1'b0;
      if (cs_fall) begin
        snap_x     <= data_x;
        snap_y     <= data_y;
        snap_z     <= data_z;
        bit_cnt    <= '0;
        first_byte <= 1'b1;
      end
      if (cs_rise) begin
        sdo    <= 1'b0;
        sdo_oe <= 1'b0;
      end else if (state_q != ST_IDLE) begin
        if (sclk_rise) begin
          rx_sr   <= wr_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          if (state_q == ST_CMD) begin
            rw      <= wr_byte[7];
            mb      <= wr_byte[6];
            addr    <= wr_byte[5:0];
            tx_load <= wr_byte[7];
          end else begin
            // With MB=0 only the first data byte of a write may commit.
            if (!rw && (mb || first_byte)) begin
              case (addr)
                ADDR_BW:  begin bw_rate     <= wr_byte; cfg_wr <= 1'b1; end
                ADDR_PWR: begin power_ctl   <= wr_byte; cfg_wr <= 1'b1; end
                ADDR_FMT: begin data_format <= wr_byte; cfg_wr <= 1'b1; end
                default:  ;
              endcase
            end
            first_byte <= 1'b0;
            if (mb) addr <= addr + 6'd1;
            tx_load <= rw;
          end
        end
        if (sclk_fall && (state_q == ST_DATA) && rw) begin
          sdo    <= tx_sr[7];
          tx_sr  <= {tx_sr[6:0], 1'b0};
          sdo_oe <= 1'b1;
        end
      end
      // The load lands one clk after the address settles, well before the next falling edge.
      if (tx_load) tx_sr <= read_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_x     <= '0;
      data_y     <= '0;
      data_z     <= '0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_z     <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (pend_valid && !busy) begin
        data_x     <= pend_x;
        data_y     <= pend_y;
        data_z     <= pend_z;
        pend_valid <= 1'b0;
      end else if (sample_valid && sample_ready) begin
        if (busy) begin
          pend_x     <= sample_x;
          pend_y     <= sample_y;
          pend_z     <= sample_z;
          pend_valid <= 1'b1;
        end else begin
          data_x <= sample_x;
          data_y <= sample_y;
          data_z <= sample_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_target.sv
// tb/tb_spi_accel_target.sv - scoreboard bench for spi_accel_target
module tb_spi_accel_target;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        cs_n = 1'b1;
  logic        sdi = 1'b0;
  logic        sdo, sdo_oe;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
  logic [7:0]  bw_rate, power_ctl, data_format;
  logic        cfg_wr, busy;

  int checks = 0;
  int fails = 0;
  int cfg_cnt = 0;
  int cnt0;
  logic [7:0] exp_q[$];

  spi_accel_target #(.SYNC_STAGES(2), .DEVID(8'hE5), .BW_RATE_RST(8'h0A)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .bw_rate(bw_rate), .power_ctl(power_ctl), .data_format(data_format),
    .cfg_wr(cfg_wr), .busy(busy)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (cfg_wr) cfg_cnt = cfg_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] tx, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      sclk = 1'b0;
      sdi  = tx[i];
      wait_clk(H);
      sclk = 1'b1;
      wait_clk(H);
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    xfer_bits(tx, 8);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    cs_n = 1'b1;
    wait_clk(6);
  endtask

  task automatic offer(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x     = x;
    sample_y     = y;
    sample_z     = z;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    wait_clk(1);
  endtask

  // Deserialises sdo on master sample edges and scores each completed byte.
  task automatic monitor();
    logic [7:0] sr;
    int cnt;
    logic [7:0] exp;
    cnt = 0;
    sr  = '0;
    forever begin
      @(posedge sclk or posedge cs_n);
      if (cs_n) begin
        cnt = 0;
      end else if (sdo_oe) begin
        sr = {sr[6:0], sdo};
        cnt++;
        if (cnt == 8) begin
          cnt = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_byte", {24'd0, sr}, 32'hFFFF_FFFF);
          end else begin
            exp = exp_q.pop_front();
            check("read_byte", {24'd0, sr}, {24'd0, exp});
          end
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    wait_clk(5);
    check("rst_sdo", {31'd0, sdo}, 32'd0);
    check("rst_sdo_oe", {31'd0, sdo_oe}, 32'd0);
    check("rst_sample_ready", {31'd0, sample_ready}, 32'd1);
    check("rst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_bw_rate", {24'd0, bw_rate}, 32'h0A);
    check("rst_power_ctl", {24'd0, power_ctl}, 32'h00);
    check("rst_data_format", {24'd0, data_format}, 32'h00);
    rst_n = 1'b1;
    wait_clk(4);

    // DEVID read
    cs_low();
    check("busy_low", {31'd0, busy}, 32'd1);
    xfer(8'h80);
    check("oe_in_cmd", {31'd0, sdo_oe}, 32'd0);
    exp_q.push_back(8'hE5);
    xfer(8'h00);
    check("oe_in_data", {31'd0, sdo_oe}, 32'd1);
    cs_high();
    check("oe_after_cs", {31'd0, sdo_oe}, 32'd0);
    check("busy_high", {31'd0, busy}, 32'd0);

    // Config writes
    cnt0 = cfg_cnt;
    cs_low(); xfer(8'h31); xfer(8'h00); cs_high();
    cs_low(); xfer(8'h2C); xfer(8'h0F); cs_high();
    check("data_format_wr", {24'd0, data_format}, 32'h00);
    check("bw_rate_wr", {24'd0, bw_rate}, 32'h0F);
    check("cfg_wr_two", cfg_cnt - cnt0, 32'd2);
    cs_low(); xfer(8'h2D); xfer(8'h08); cs_high();
    check("power_ctl_wr", {24'd0, power_ctl}, 32'h08);

    // Multi-byte coherent read with a sample offered mid-transfer
    offer(16'h1234, 16'hFFFE, 16'h0100);
    cs_low();
    xfer(8'hF2);
    exp_q.push_back(8'h34);
    xfer(8'h00);
    offer(16'hABCD, 16'h8001, 16'h7F00);
    check("ready_held", {31'd0, sample_ready}, 32'd0);
    exp_q.push_back(8'h12); xfer(8'h00);
    exp_q.push_back(8'hFE); xfer(8'h00);
    exp_q.push_back(8'hFF); xfer(8'h00);
    exp_q.push_back(8'h00); xfer(8'h00);
    exp_q.push_back(8'h01); xfer(8'h00);
    check("ready_still_held", {31'd0, sample_ready}, 32'd0);
    cs_high();
    check("ready_restored", {31'd0, sample_ready}, 32'd1);
    cs_low();
    xfer(8'hF2);
    exp_q.push_back(8'hCD); xfer(8'h00);
    exp_q.push_back(8'hAB); xfer(8'h00);
    exp_q.push_back(8'h01); xfer(8'h00);
    exp_q.push_back(8'h80); xfer(8'h00);
    exp_q.push_back(8'h00); xfer(8'h00);
    exp_q.push_back(8'h7F); xfer(8'h00);
    cs_high();

    // Address wrap 0x3F -> 0x00
    cs_low(); xfer(8'hFF);
    exp_q.push_back(8'h00); xfer(8'h00);
    exp_q.push_back(8'hE5); xfer(8'h00);
    cs_high();

    // MB=0 write: second byte ignored
    cnt0 = cfg_cnt;
    cs_low(); xfer(8'h2C); xfer(8'h0A); xfer(8'h55); cs_high();
    check("bw_rate_mb0", {24'd0, bw_rate}, 32'h0A);
    check("cfg_wr_mb0", cfg_cnt - cnt0, 32'd1);
    // MB=0 read repeats the same byte
    cs_low(); xfer(8'hAC);
    exp_q.push_back(8'h0A); xfer(8'h00);
    exp_q.push_back(8'h0A); xfer(8'h00);
    cs_high();

    // Abort after 5 data bits
    cnt0 = cfg_cnt;
    cs_low(); xfer(8'h2D); xfer_bits(8'hFF, 5); cs_high();
    check("power_ctl_abort", {24'd0, power_ctl}, 32'h08);
    check("cfg_wr_abort", cfg_cnt - cnt0, 32'd0);
    cs_low(); xfer(8'hAD);
    exp_q.push_back(8'h08); xfer(8'h00);
    cs_high();

    // Reset during a read data phase
    cs_low(); xfer(8'h80); xfer_bits(8'h00, 4);
    rst_n = 1'b0;
    wait_clk(3);
    check("rst_mid_oe", {31'd0, sdo_oe}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_power_ctl", {24'd0, power_ctl}, 32'h00);
    check("rst_mid_bw_rate", {24'd0, bw_rate}, 32'h0A);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    cs_low(); xfer(8'h80);
    exp_q.push_back(8'hE5); xfer(8'h00);
    cs_high();
    cs_low(); xfer(8'hF2);
    exp_q.push_back(8'h00); xfer(8'h00);
    exp_q.push_back(8'h00); xfer(8'h00);
    cs_high();

    wait_clk(10);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
